// File: rtl/dequantize_if.sv
// Bus bundle for the dequantizer: start/config, quantized-buffer read port
// and INT18 output-buffer write port.
interface dequantize_if;
    localparam int unsigned VL      = 16;
    localparam int unsigned TRUNC_W = 18;
    localparam int unsigned DATA8_W = 8;
    localparam int unsigned ADDR_W  = 8;

    logic                      i_start;
    logic [1:0]                i_mode;
    logic [TRUNC_W*VL-1:0]     i_vsq_sf;
    logic [TRUNC_W-1:0]        i_int4_sf;
    logic [TRUNC_W-1:0]        i_int8_sf;
    logic [ADDR_W-1:0]         o_buf_addr;
    logic [DATA8_W*VL-1:0]     i_buf_data;
    logic                      o_out_we;
    logic [ADDR_W-1:0]         o_out_addr;
    logic [TRUNC_W*VL-1:0]     o_out_data;
    logic                      o_busy;
    logic                      o_finish;

    modport slave (
        input  i_start, i_mode, i_vsq_sf, i_int4_sf, i_int8_sf, i_buf_data,
        output o_buf_addr, o_out_we, o_out_addr, o_out_data, o_busy, o_finish
    );

    modport master (
        output i_start, i_mode, i_vsq_sf, i_int4_sf, i_int8_sf, i_buf_data,
        input  o_buf_addr, o_out_we, o_out_addr, o_out_data, o_busy, o_finish
    );
endinterface

// File: rtl/dequantize.sv
// Streams a 64-vector block of packed INT4/INT8 lanes, rescales each lane by
// its (VSQ / per-tensor) scale factor and writes saturated INT18 vectors.
module dequantize (
    input  logic         i_clk,
    input  logic         i_rst_n,
    dequantize_if.slave  io_dq
);
    localparam int unsigned VL      = 16;
    localparam int unsigned TRUNC_W = 18;
    localparam int unsigned DATA8_W = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned VEC_CNT = 64;
    localparam int unsigned PROD_W  = 27;

    localparam logic [1:0] MODE_INT4_VSQ = 2'd0;
    localparam logic [1:0] MODE_INT4     = 2'd1;

    localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(VEC_CNT - 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX   = 27'sd131071;
    localparam logic signed [PROD_W-1:0] SAT_MIN   = -27'sd131072;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       w_start_acc;

    logic [1:0]                 r_mode;
    logic [TRUNC_W*VL-1:0]      r_vsq_sf;
    logic [TRUNC_W-1:0]         r_int4_sf;
    logic [TRUNC_W-1:0]         r_int8_sf;

    logic [ADDR_W-1:0]          r_buf_addr;
    logic                       r_s1_vld;
    logic [ADDR_W-1:0]          r_s1_addr;
    logic                       r_out_we;
    logic [ADDR_W-1:0]          r_out_addr;
    logic [TRUNC_W*VL-1:0]      r_out_data;
    logic                       r_busy;
    logic                       r_finish;

    logic                       w_last_rd;
    logic                       w_last_wr;
    logic signed [DATA8_W-1:0]  w_q    [VL];
    logic [TRUNC_W-1:0]         w_sf   [VL];
    logic signed [PROD_W-1:0]   w_prod [VL];
    logic [TRUNC_W*VL-1:0]      w_res;

    assign w_last_rd = (r_buf_addr == LAST_ADDR);
    assign w_last_wr = r_out_we && (r_out_addr == LAST_ADDR);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; starts are only accepted from idle
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_dq.i_start) begin
                    w_state_nxt = S_RUN;
                    w_start_acc = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last_rd) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_wr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shadow copies of mode and scale factors, frozen for the whole block
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode    <= 2'b00;
            r_vsq_sf  <= '0;
            r_int4_sf <= '0;
            r_int8_sf <= '0;
        end else if (w_start_acc) begin
            r_mode    <= io_dq.i_mode;
            r_vsq_sf  <= io_dq.i_vsq_sf;
            r_int4_sf <= io_dq.i_int4_sf;
            r_int8_sf <= io_dq.i_int8_sf;
        end
    end

    // Read counter and read-valid / address pipeline stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_addr <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_addr  <= '0;
            r_busy     <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_buf_addr <= '0;
            end else if ((r_state == S_RUN) && !w_last_rd) begin
                r_buf_addr <= r_buf_addr + ADDR_W'(1);
            end
            r_s1_vld  <= (r_state == S_RUN);
            r_s1_addr <= r_buf_addr;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    // Per-lane unpack, scale and clamp to signed 18 bits
    always_comb begin
        w_res = '0;
        for (int i = 0; i < int'(VL); i++) begin
            if ((r_mode == MODE_INT4_VSQ) || (r_mode == MODE_INT4)) begin
                w_q[i] = {{4{io_dq.i_buf_data[i*4+3]}}, io_dq.i_buf_data[i*4 +: 4]};
            end else begin
                w_q[i] = io_dq.i_buf_data[i*DATA8_W +: DATA8_W];
            end

            if (r_mode == MODE_INT4_VSQ) begin
                w_sf[i] = r_vsq_sf[i*TRUNC_W +: TRUNC_W];
            end else if (r_mode == MODE_INT4) begin
                w_sf[i] = r_int4_sf;
            end else begin
                w_sf[i] = r_int8_sf;
            end

            w_prod[i] = PROD_W'(w_q[i]) * PROD_W'($signed({1'b0, w_sf[i]}));

            if (w_prod[i] > SAT_MAX) begin
                w_res[i*TRUNC_W +: TRUNC_W] = TRUNC_W'(SAT_MAX);
            end else if (w_prod[i] < SAT_MIN) begin
                w_res[i*TRUNC_W +: TRUNC_W] = TRUNC_W'(SAT_MIN);
            end else begin
                w_res[i*TRUNC_W +: TRUNC_W] = TRUNC_W'(w_prod[i]);
            end
        end
    end

    // Output register stage; data holds its value between writes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_we   <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_finish   <= 1'b0;
        end else begin
            r_out_we <= r_s1_vld;
            r_finish <= r_s1_vld && (r_s1_addr == LAST_ADDR);
            if (r_s1_vld) begin
                r_out_addr <= r_s1_addr;
                r_out_data <= w_res;
            end
        end
    end

    assign io_dq.o_buf_addr = r_buf_addr;
    assign io_dq.o_out_we   = r_out_we;
    assign io_dq.o_out_addr = r_out_addr;
    assign io_dq.o_out_data = r_out_data;
    assign io_dq.o_busy     = r_busy;
    assign io_dq.o_finish   = r_finish;

endmodule
